unit_test_sequencer: RTL and testbench

//  Synthesizable sequencer that launches per-unit self-tests (cpu, rf, alu, ...) over start/done handshakes.

---
 rtl/unit_test_sequencer.sv | 168 ++++++++++++++++
 tb/tb_unit_test_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_test_sequencer.sv
// unit_test_sequencer: launches per-unit self-tests over start/done handshakes,
// either a single selected unit or all units in index order, with a per-unit
// cycle timeout. Accumulates pass/fail/timeout masks for the top-level controller.
module unit_test_sequencer #(
    parameter int N_UNITS = 3,
    parameter int TIMEOUT = 10000,
    parameter int CYC_W   = 16,
    localparam int SW     = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic [SW-1:0]      i_sel,
    output logic [N_UNITS-1:0] o_unit_start,
    input  logic [N_UNITS-1:0] i_unit_done,
    input  logic [N_UNITS-1:0] i_unit_pass,
    output logic               o_busy,
    output logic               o_done,
    output logic [SW-1:0]      o_cur_unit,
    output logic [N_UNITS-1:0] o_pass_mask,
    output logic [N_UNITS-1:0] o_fail_mask,
    output logic [N_UNITS-1:0] o_tmo_mask,
    output logic [CYC_W-1:0]   o_last_cycles,
    output logic               o_bad_sel
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    // Widened by one bit so the unit count itself and TIMEOUT+1 are representable.
    localparam logic [SW:0]    N_LIM  = (SW+1)'(N_UNITS);
    localparam logic [SW:0]    LAST_U = (SW+1)'(N_UNITS - 1);
    localparam logic [CYC_W:0] TMO_X  = (CYC_W+1)'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic             run_all;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W:0]   cyc_inc;
    logic             sel_ok;
    logic             unit_done;
    logic             unit_pass;
    logic             tmo_hit;
    logic             more_units;

    // Only the active unit's handshake is observed; other channels are ignored.
    assign unit_done  = i_unit_done[o_cur_unit];
    assign unit_pass  = i_unit_pass[o_cur_unit];
    assign sel_ok     = ({1'b0, i_sel} < N_LIM);
    assign cyc_inc    = {1'b0, cyc_cnt} + 1'b1;
    assign tmo_hit    = (cyc_inc == TMO_X);
    assign more_units = run_all && ({1'b0, o_cur_unit} < LAST_U);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection and the state-decoded launch/done pulses.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        o_unit_start = '0;
        o_done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_mode || sel_ok) ? S_LAUNCH : S_FINISH;
                end
            end
            S_LAUNCH: begin
                o_unit_start = N_UNITS'(1) << o_cur_unit;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (unit_done || tmo_hit) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                state_nxt = more_units ? S_LAUNCH : S_FINISH;
            end
            S_FINISH: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run context, cycle counter and result bookkeeping.
    // NOTE: every register here is small control state, so all of it is reset;
    // there is no storage array that could be left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_all       <= 1'b0;
            cyc_cnt       <= '0;
            o_busy        <= 1'b0;
            o_cur_unit    <= '0;
            o_pass_mask   <= '0;
            o_fail_mask   <= '0;
            o_tmo_mask    <= '0;
            o_last_cycles <= '0;
            o_bad_sel     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_pass_mask <= '0;
                        o_fail_mask <= '0;
                        o_tmo_mask  <= '0;
                        if (i_mode || sel_ok) begin
                            run_all       <= i_mode;
                            o_cur_unit    <= i_mode ? '0 : i_sel;
                            o_busy        <= 1'b1;
                            o_bad_sel     <= 1'b0;
                            o_last_cycles <= '0;
                        end else begin
                            // Rejected selection: report it and finish without launching.
                            o_bad_sel <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    cyc_cnt <= '0;
                end
                S_WAIT: begin
                    cyc_cnt <= cyc_inc[CYC_W-1:0];
                    // A done arriving on the timeout cycle still counts as a verdict.
                    if (unit_done) begin
                        if (unit_pass) begin
                            o_pass_mask[o_cur_unit] <= 1'b1;
                        end else begin
                            o_fail_mask[o_cur_unit] <= 1'b1;
                        end
                        o_last_cycles <= cyc_inc[CYC_W-1:0];
                    end else if (tmo_hit) begin
                        o_tmo_mask[o_cur_unit] <= 1'b1;
                        o_last_cycles          <= CYC_W'(TIMEOUT);
                    end
                end
                S_NEXT: begin
                    if (more_units) begin
                        o_cur_unit <= o_cur_unit + 1'b1;
                    end
                end
                S_FINISH: begin
                    o_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unit_test_sequencer.sv
// Bench for unit_test_sequencer: a run-level model expands each accepted start
// into the expected per-cycle output trace; a compare process checks the DUT
// against that trace every cycle, plus literal checks on directed scenarios.
module tb_unit_test_sequencer;

    localparam int N   = 3;
    localparam int TMO = 8;
    localparam int CW  = 16;
    localparam int SW  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_start = 1'b0;
    logic          i_mode = 1'b0;
    logic [SW-1:0] i_sel = '0;
    logic [N-1:0]  i_unit_done = '0;
    logic [N-1:0]  i_unit_pass = '0;
    logic [N-1:0]  o_unit_start;
    logic          o_busy;
    logic          o_done;
    logic [SW-1:0] o_cur_unit;
    logic [N-1:0]  o_pass_mask;
    logic [N-1:0]  o_fail_mask;
    logic [N-1:0]  o_tmo_mask;
    logic [CW-1:0] o_last_cycles;
    logic          o_bad_sel;

    always #5 clk = ~clk;

    unit_test_sequencer #(.N_UNITS(N), .TIMEOUT(TMO), .CYC_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_sel        (i_sel),
        .o_unit_start (o_unit_start),
        .i_unit_done  (i_unit_done),
        .i_unit_pass  (i_unit_pass),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cur_unit   (o_cur_unit),
        .o_pass_mask  (o_pass_mask),
        .o_fail_mask  (o_fail_mask),
        .o_tmo_mask   (o_tmo_mask),
        .o_last_cycles(o_last_cycles),
        .o_bad_sel    (o_bad_sel)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [N-1:0]  us;
        logic          dn;
        logic          bz;
        logic [SW-1:0] cur;
        logic [N-1:0]  p;
        logic [N-1:0]  f;
        logic [N-1:0]  t;
        logic [CW-1:0] last;
        logic          bsel;
    } snap_t;

    // Expected outputs, one entry per cycle of an active run.
    snap_t exp_q[$];
    // Result registers as the model currently believes them to be.
    logic [N-1:0]  m_p = '0, m_f = '0, m_t = '0;
    logic [CW-1:0] m_last = '0;
    logic          m_bad = 1'b0;
    logic [SW-1:0] m_cur = '0;

    int           done_cnt = 0;
    logic [N-1:0] us_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic snap_t mk(input logic [N-1:0] us, input logic dn, input logic bz);
        snap_t s;
        s.us   = us;
        s.dn   = dn;
        s.bz   = bz;
        s.cur  = m_cur;
        s.p    = m_p;
        s.f    = m_f;
        s.t    = m_t;
        s.last = m_last;
        s.bsel = m_bad;
        return s;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_p = '0; m_f = '0; m_t = '0; m_last = '0; m_bad = 1'b0; m_cur = '0;
    endfunction

    // Expand one accepted start into its cycle-by-cycle trace:
    // LAUNCH, W wait cycles, NEXT per unit, then one FINISH cycle.
    function automatic void plan(input bit mode, input int sel, input int dly[N], input bit pas[N]);
        int lo, hi, w;
        if (!mode && sel >= N) begin
            m_p = '0; m_f = '0; m_t = '0; m_bad = 1'b1;
            exp_q.push_back(mk('0, 1'b1, 1'b0));
            return;
        end
        m_p = '0; m_f = '0; m_t = '0; m_last = '0; m_bad = 1'b0;
        lo = mode ? 0 : sel;
        hi = mode ? N - 1 : sel;
        for (int u = lo; u <= hi; u++) begin
            m_cur = SW'(u);
            exp_q.push_back(mk(N'(1 << u), 1'b0, 1'b1));
            w = (dly[u] >= 1 && dly[u] <= TMO) ? dly[u] : TMO;
            for (int j = 0; j < w; j++) exp_q.push_back(mk('0, 1'b0, 1'b1));
            if (dly[u] >= 1 && dly[u] <= TMO) begin
                if (pas[u]) m_p[u] = 1'b1; else m_f[u] = 1'b1;
                m_last = CW'(w);
            end else begin
                m_t[u] = 1'b1;
                m_last = CW'(TMO);
            end
            exp_q.push_back(mk('0, 1'b0, 1'b1));
        end
        exp_q.push_back(mk('0, 1'b1, 1'b1));
    endfunction

    // Compare process: every cycle, shortly after the rising edge.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = mk('0, 1'b0, 1'b0);
            check("unit_start",  32'(o_unit_start),  32'(e.us));
            check("done",        32'(o_done),        32'(e.dn));
            check("busy",        32'(o_busy),        32'(e.bz));
            check("cur_unit",    32'(o_cur_unit),    32'(e.cur));
            check("pass_mask",   32'(o_pass_mask),   32'(e.p));
            check("fail_mask",   32'(o_fail_mask),   32'(e.f));
            check("tmo_mask",    32'(o_tmo_mask),    32'(e.t));
            check("last_cycles", 32'(o_last_cycles), 32'(e.last));
            check("bad_sel",     32'(o_bad_sel),     32'(e.bsel));
            if (o_done === 1'b1) done_cnt++;
            if (o_unit_start !== '0) us_log.push_back(o_unit_start);
        end
    end

    // Random activity on everything except the awaited unit's done bit.
    task automatic noise(input int excl);
        logic [N-1:0] m;
        m = N'($urandom);
        if (excl >= 0) m[excl] = 1'b0;
        i_unit_done = m;
        i_unit_pass = N'($urandom);
        i_start     = 1'($urandom);
        i_sel       = SW'($urandom);
        i_mode      = 1'($urandom);
    endtask

    task automatic quiet();
        i_start     = 1'b0;
        i_unit_done = N'($urandom);
        i_unit_pass = N'($urandom);
        i_sel       = SW'($urandom);
        i_mode      = 1'($urandom);
    endtask

    // Called at a falling edge while idle; returns at a falling edge while idle.
    // dly[u]: wait cycle on which unit u raises done (0 or >TMO = silent).
    task automatic run(input bit mode, input int sel, input int dly[N], input bit pas[N],
                       input int abort_u);
        int lo, hi, w;
        i_start     = 1'b1;
        i_mode      = mode;
        i_sel       = SW'(sel);
        i_unit_done = '0;
        plan(mode, sel, dly, pas);
        if (!mode && sel >= N) begin
            @(negedge clk); noise(-1);
            @(negedge clk); quiet();
            return;
        end
        lo = mode ? 0 : sel;
        hi = mode ? N - 1 : sel;
        for (int u = lo; u <= hi; u++) begin
            @(negedge clk); noise(u);
            w = (dly[u] >= 1 && dly[u] <= TMO) ? dly[u] : TMO;
            for (int j = 1; j <= w; j++) begin
                @(negedge clk); noise(u);
                if (u == abort_u && j == 3) begin
                    i_start = 1'b0;
                    reset   = 1'b1;
                    model_reset();
                    @(negedge clk);
                    reset = 1'b0;
                    quiet();
                    return;
                end
                if (j == dly[u]) begin
                    i_unit_done[u] = 1'b1;
                    i_unit_pass[u] = pas[u];
                end
            end
            @(negedge clk); noise(u);
        end
        @(negedge clk); noise(-1);
        @(negedge clk); quiet();
    endtask

    initial begin
        int  d0;
        int  dly[N];
        bit  pas[N];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single unit 1, done+pass on wait cycle 5.
        d0 = done_cnt;
        run(1'b0, 1, '{0, 5, 0}, '{0, 1, 0}, -1);
        check("t1_pass_mask", 32'(o_pass_mask), 32'b010);
        check("t1_last", 32'(o_last_cycles), 32'd5);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_busy_after", 32'(o_busy), 32'd0);

        // All units: pass/fail/pass, launched in index order.
        us_log.delete();
        run(1'b1, 0, '{2, 3, 4}, '{1, 0, 1}, -1);
        check("t2_pass", 32'(o_pass_mask), 32'b101);
        check("t2_fail", 32'(o_fail_mask), 32'b010);
        check("t2_tmo", 32'(o_tmo_mask), 32'b000);
        check("t2_launches", 32'(us_log.size()), 32'd3);
        if (us_log.size() == 3) begin
            check("t2_launch0", 32'(us_log[0]), 32'b001);
            check("t2_launch1", 32'(us_log[1]), 32'b010);
            check("t2_launch2", 32'(us_log[2]), 32'b100);
        end

        // Out-of-range selection is rejected without a launch.
        us_log.delete();
        d0 = done_cnt;
        run(1'b0, 3, '{1, 1, 1}, '{1, 1, 1}, -1);
        check("t3_bad_sel", 32'(o_bad_sel), 32'd1);
        check("t3_no_launch", 32'(us_log.size()), 32'd0);
        check("t3_masks", 32'({o_pass_mask, o_fail_mask, o_tmo_mask}), 32'd0);
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Timeout, then done landing exactly on the timeout cycle.
        run(1'b0, 0, '{0, 0, 0}, '{0, 0, 0}, -1);
        check("t4_tmo", 32'(o_tmo_mask), 32'b001);
        check("t4_last", 32'(o_last_cycles), 32'd8);
        run(1'b0, 0, '{8, 0, 0}, '{1, 0, 0}, -1);
        check("t4b_pass", 32'(o_pass_mask), 32'b001);
        check("t4b_tmo", 32'(o_tmo_mask), 32'b000);
        run(1'b0, 0, '{8, 0, 0}, '{0, 0, 0}, -1);
        check("t4c_fail", 32'(o_fail_mask), 32'b001);
        check("t4c_tmo", 32'(o_tmo_mask), 32'b000);

        // Stray done bits and start pulses while busy (noise is always on).
        run(1'b0, 0, '{4, 0, 0}, '{1, 0, 0}, -1);
        check("t5_pass", 32'(o_pass_mask), 32'b001);
        check("t5_fail", 32'(o_fail_mask), 32'b000);
        check("t5_last", 32'(o_last_cycles), 32'd4);

        // Reset during WAIT of unit 1 in run-all mode, then a clean run.
        d0 = done_cnt;
        run(1'b1, 0, '{2, 0, 0}, '{1, 0, 0}, 1);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check("t6_cleared", 32'({o_busy, o_pass_mask, o_tmo_mask, o_last_cycles}), 32'd0);
        run(1'b1, 0, '{1, 9, 3}, '{0, 1, 1}, -1);
        check("t6_fail", 32'(o_fail_mask), 32'b001);
        check("t6_tmo", 32'(o_tmo_mask), 32'b010);
        check("t6_pass", 32'(o_pass_mask), 32'b100);
        check("t6_last", 32'(o_last_cycles), 32'd3);

        // Randomized runs against the trace model.
        for (int r = 0; r < 60; r++) begin
            for (int u = 0; u < N; u++) begin
                dly[u] = int'($urandom_range(0, 10));
                pas[u] = 1'($urandom);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); quiet();
            end
            run(1'($urandom), int'($urandom_range(0, 3)), dly, pas, -1);
        end

        repeat (3) @(negedge clk);
        check("end_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
